rx_unit: RTL and testbench
==========================

RX_UNIT -- requirements
Module: rx_unit

Interface
REQ-001 Parameter RX_DATA_SIZE, default 8: data bits per frame.
REQ-002 Parameter CLKS_PER_BIT, default 868: i_clock cycles per bit (115200 baud at 100 MHz); legal range 8..65535.
REQ-003 i_clock  input  1  sole clock; all state on rising edge.
REQ-004 i_reset  input  1  asynchronous, active-high reset.
REQ-005 i_rx  input  1  asynchronous serial line, idle high.
REQ-006 i_read  input  1  consumer acknowledges o_rxdata; meaningful only while o_valid=1.
REQ-007 o_rxdata  output  RX_DATA_SIZE  last good received word.
REQ-008 o_valid  output  1  o_rxdata holds an unread word.
REQ-009 o_busy  output  1  frame reception in progress (state != IDLE).
REQ-010 o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 o_overrun  output  1  one-cycle pulse: good word completed while o_valid=1.

Function
REQ-012 i_rx SHALL pass a 2-flop synchronizer; all decisions use the synchronized value (rx_s).
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE: rx_s=0 -> START, bit counter cleared, tick counter cleared.
REQ-015 START: after CLKS_PER_BIT/2 cycles (integer division), sample rx_s; 0 -> DATA, 1 -> IDLE (glitch, no flags).
REQ-016 DATA: sample every CLKS_PER_BIT cycles after the start mid-point, LSB first, into a shift register; after RX_DATA_SIZE samples -> STOP.
REQ-017 STOP: sample after CLKS_PER_BIT cycles; always -> IDLE on the sample cycle, so a start bit beginning half a bit later is captured.
REQ-018 Stop sample 1: on the next cycle, o_rxdata <= shift register, o_valid <= 1; if o_valid was already 1 and no i_read on the same cycle, o_overrun pulses for that cycle.
REQ-019 Stop sample 0: on the next cycle, o_frame_err pulses; o_rxdata and o_valid unchanged.
REQ-020 i_read=1 while o_valid=1 clears o_valid next cycle; i_read while o_valid=0 is ignored.
REQ-021 Simultaneous i_read and new-word load: load wins, o_valid stays 1, no overrun.
REQ-022 Tick counter width SHALL be $clog2(CLKS_PER_BIT); the counter wraps to 0 at each sample.
REQ-023 Line held low in IDLE (break): after one frame error, no new START until rx_s has been 1 for at least one cycle.

Reset
REQ-024 i_reset SHALL asynchronously force: state IDLE, counters 0, synchronizer flops 1, shift register 0, o_rxdata 0, o_valid 0, o_busy 0, o_frame_err 0, o_overrun 0 (and o_parity_err 0 when present).
REQ-025 Reset mid-frame SHALL discard the partial word; reception restarts on the first falling edge after release.

Configuration
REQ-026 Macro RX_UNIT_PARITY_EN defined: one even-parity bit follows the data bits (state PARITY between DATA and STOP); port o_parity_err (output, 1) pulses with the load cycle on mismatch; the word is still loaded and o_valid still set.
REQ-027 Macro RX_UNIT_PARITY_EN undefined: no parity bit, no PARITY state, no o_parity_err port; frame = start + RX_DATA_SIZE data + stop.

Structure
REQ-028 State encoding localparams and the default baud constant SHALL live in the shared uart package, so that the transmitter and receiver use the same values.
REQ-029 Natural sub-module: rx_sync (2-flop synchronizer, reset value 1); all else stays in rx_unit.

Verification (CLKS_PER_BIT=16, RX_DATA_SIZE=8)
REQ-030 Send 0xA5, good stop -> o_rxdata=0xA5, o_valid=1 exactly 1 cycle after the mid-stop sample; i_read -> o_valid=0 next cycle.
REQ-031 Low pulse of 4 cycles on idle line -> return to IDLE, no o_valid, no o_frame_err.
REQ-032 Send 0x3C with stop bit low -> o_frame_err pulses once, o_valid stays 0, o_rxdata unchanged.
REQ-033 Send 0x11 then 0x22 back-to-back with no i_read -> o_overrun pulses once, o_rxdata=0x22, o_valid=1.
REQ-034 Assert i_reset during bit 3 of 0xFF, then send 0x5A -> all outputs 0 during reset, then o_rxdata=0x5A.
REQ-035 RX_UNIT_PARITY_EN: send 0x07 with parity bit 0 -> o_parity_err pulses, o_rxdata=0x07, o_valid=1.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Values shared by the UART transmitter and receiver: state encodings,
// the state enum built from them, and the default baud divider.
// Optional macro: RX_UNIT_PARITY_EN adds the PARITY state.
// ---------------------------------------------------------------------------
package uart_pkg;

    // 115200 baud at 100 MHz
    localparam int UART_CLKS_PER_BIT = 868;

    localparam logic [2:0] UART_ST_IDLE   = 3'd0;
    localparam logic [2:0] UART_ST_START  = 3'd1;
    localparam logic [2:0] UART_ST_DATA   = 3'd2;
    localparam logic [2:0] UART_ST_STOP   = 3'd3;
`ifdef RX_UNIT_PARITY_EN
    localparam logic [2:0] UART_ST_PARITY = 3'd4;
`endif

    typedef enum logic [2:0] {
        ST_IDLE   = UART_ST_IDLE,
        ST_START  = UART_ST_START,
        ST_DATA   = UART_ST_DATA,
`ifdef RX_UNIT_PARITY_EN
        ST_PARITY = UART_ST_PARITY,
`endif
        ST_STOP   = UART_ST_STOP
    } uart_state_t;

endpackage

// File: rtl/rx_sync.sv
// ---------------------------------------------------------------------------
// rx_sync
// Two-flop synchronizer for the asynchronous serial line. Both flops reset
// to 1 so that an idle (high) line is seen during and after reset.
// Ports:
//   i_clock  clock
//   i_reset  asynchronous active-high reset
//   i_d      asynchronous input
//   o_q      synchronized output
// ---------------------------------------------------------------------------
module rx_sync (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [1:0] r_ff;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_ff <= 2'b11;
        end else begin
            r_ff <= {r_ff[0], i_d};
        end
    end

    assign o_q = r_ff[1];

endmodule

// File: rtl/rx_unit.sv
// ---------------------------------------------------------------------------
// rx_unit
// UART receiver: start + RX_DATA_SIZE data bits (LSB first) + stop, with a
// single-entry output register handshaken by i_read.
// Optional macro: RX_UNIT_PARITY_EN adds an even-parity bit after the data
// bits and the o_parity_err port.
// Ports:
//   i_clock      clock
//   i_reset      asynchronous active-high reset
//   i_rx         serial line, idle high (asynchronous)
//   i_read       consumer takes o_rxdata (only meaningful while o_valid)
//   o_rxdata     last good word
//   o_valid      o_rxdata holds an unread word
//   o_busy       frame reception in progress
//   o_frame_err  one-cycle pulse: stop bit sampled low
//   o_overrun    one-cycle pulse: new word loaded over an unread one
//   o_parity_err one-cycle pulse with the load on parity mismatch (option)
//
// state  | meaning
// IDLE   | waiting for rx_s low (blocked after a break until line goes high)
// START  | counting to the start-bit mid-point, re-checking the line
// DATA   | sampling data bits one bit period apart
// PARITY | sampling the parity bit (option only)
// STOP   | sampling the stop bit, then loading the word or flagging an error
// ---------------------------------------------------------------------------
module rx_unit
    import uart_pkg::*;
#(
    parameter int RX_DATA_SIZE = 8,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_rx,
    input  logic                    i_read,
    output logic [RX_DATA_SIZE-1:0] o_rxdata,
    output logic                    o_valid,
    output logic                    o_busy,
    output logic                    o_frame_err,
    output logic                    o_overrun
`ifdef RX_UNIT_PARITY_EN
    ,
    output logic                    o_parity_err
`endif
);

    localparam int TICK_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(RX_DATA_SIZE + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(RX_DATA_SIZE - 1);

    logic                    w_rx_s;
    logic [RX_DATA_SIZE-1:0] w_shift_next;

    uart_state_t             r_state;
    logic [TICK_W-1:0]       r_tick;
    logic [BIT_W-1:0]        r_bit;
    logic [RX_DATA_SIZE-1:0] r_shift;
    logic [RX_DATA_SIZE-1:0] r_rxdata;
    logic                    r_valid;
    logic                    r_frame_err;
    logic                    r_overrun;
    // set by a low stop bit; holds off a new start until the line is high
    logic                    r_break;
`ifdef RX_UNIT_PARITY_EN
    logic                    r_par_err;
    logic                    r_parity_err;
`endif

    rx_sync u_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (w_rx_s)
    );

    // LSB-first: new bit enters at the top and walks down
    assign w_shift_next = RX_DATA_SIZE'({w_rx_s, r_shift} >> 1);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_tick      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_rxdata    <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_break     <= 1'b0;
`ifdef RX_UNIT_PARITY_EN
            r_par_err    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef RX_UNIT_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            // a load in STOP below overrides this clear
            if (i_read) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    r_tick <= '0;
                    r_bit  <= '0;
                    if (w_rx_s) begin
                        r_break <= 1'b0;
                    end else if (!r_break) begin
                        r_state <= ST_START;
                    end
                end

                ST_START: begin
                    if (r_tick == TICK_MID) begin
                        r_tick  <= '0;
                        r_state <= w_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end

                ST_DATA: begin
                    if (r_tick == TICK_LAST) begin
                        r_tick  <= '0;
                        r_shift <= w_shift_next;
                        if (r_bit == BIT_LAST) begin
`ifdef RX_UNIT_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_bit <= r_bit + BIT_W'(1);
                        end
                    end else begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end

`ifdef RX_UNIT_PARITY_EN
                ST_PARITY: begin
                    if (r_tick == TICK_LAST) begin
                        r_tick    <= '0;
                        // even parity: received bit must equal XOR of data
                        r_par_err <= w_rx_s ^ (^r_shift);
                        r_state   <= ST_STOP;
                    end else begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end
`endif

                ST_STOP: begin
                    if (r_tick == TICK_LAST) begin
                        r_tick  <= '0;
                        // leave at the mid-stop sample so a start bit half a
                        // bit later is still caught
                        r_state <= ST_IDLE;
                        if (w_rx_s) begin
                            r_rxdata  <= r_shift;
                            r_valid   <= 1'b1;
                            r_overrun <= r_valid && !i_read;
`ifdef RX_UNIT_PARITY_EN
                            r_parity_err <= r_par_err;
`endif
                        end else begin
                            r_frame_err <= 1'b1;
                            r_break     <= 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + TICK_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_rxdata    = r_rxdata;
    assign o_valid     = r_valid;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
`ifdef RX_UNIT_PARITY_EN
    assign o_parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_rx_unit.sv
// ---------------------------------------------------------------------------
// tb_rx_unit
// Bench for rx_unit at CLKS_PER_BIT=16, RX_DATA_SIZE=8. A frame-level model
// predicts, per sent frame, the cycle its result appears and what it is;
// a negedge process compares all outputs against it every cycle. Directed
// literal checks pin latency and the results of each scenario.
// Honors RX_UNIT_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_rx_unit;

    localparam int CPB = 16;
    localparam int DW  = 8;
`ifdef RX_UNIT_PARITY_EN
    localparam int PB      = 1;
    localparam int LAT_LIT = 171;
`else
    localparam int PB      = 0;
    localparam int LAT_LIT = 155;
`endif

    logic          i_clock = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_rx    = 1'b1;
    logic          i_read  = 1'b0;
    logic [DW-1:0] o_rxdata;
    logic          o_valid;
    logic          o_busy;
    logic          o_frame_err;
    logic          o_overrun;
`ifdef RX_UNIT_PARITY_EN
    logic          o_parity_err;
    int            pe_cnt = 0;
    logic          m_pe = 1'b0;
`endif

    rx_unit #(
        .RX_DATA_SIZE (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_rx        (i_rx),
        .i_read      (i_read),
        .o_rxdata    (o_rxdata),
        .o_valid     (o_valid),
        .o_busy      (o_busy),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
`ifdef RX_UNIT_PARITY_EN
        ,
        .o_parity_err(o_parity_err)
`endif
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        int            lc;    // first cycle the result is visible
        logic [DW-1:0] d;
        bit            ok;    // stop bit high
        bit            pe;    // parity mismatch
    } ev_t;

    ev_t  ev_q[$];
    int   busy_lo[$];
    int   busy_hi[$];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data  = '0;
    logic          m_fe    = 1'b0;
    logic          m_ovr   = 1'b0;
    logic          eb;
    logic          prev_valid = 1'b0;
    int            fe_cnt = 0;
    int            ovr_cnt = 0;
    int            rise_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge i_clock) cyc <= cyc + 1;

    // per-cycle compare against the frame-level model
    always @(negedge i_clock) begin
        if (i_reset) begin
            chk("rst_valid", 32'(o_valid), 0);
            chk("rst_data", 32'(o_rxdata), 0);
            chk("rst_busy", 32'(o_busy), 0);
            chk("rst_ferr", 32'(o_frame_err), 0);
            chk("rst_ovr", 32'(o_overrun), 0);
            m_valid = 1'b0;
            m_data  = '0;
            m_fe    = 1'b0;
            m_ovr   = 1'b0;
            ev_q.delete();
            busy_lo.delete();
            busy_hi.delete();
`ifdef RX_UNIT_PARITY_EN
            chk("rst_perr", 32'(o_parity_err), 0);
            m_pe = 1'b0;
`endif
        end else begin
            eb = 1'b0;
            for (int i = 0; i < busy_lo.size(); i++)
                if (cyc >= busy_lo[i] && cyc < busy_hi[i]) eb = 1'b1;
            chk("valid", 32'(o_valid), 32'(m_valid));
            chk("rxdata", 32'(o_rxdata), 32'(m_data));
            chk("busy", 32'(o_busy), 32'(eb));
            chk("frame_err", 32'(o_frame_err), 32'(m_fe));
            chk("overrun", 32'(o_overrun), 32'(m_ovr));
`ifdef RX_UNIT_PARITY_EN
            chk("parity_err", 32'(o_parity_err), 32'(m_pe));
            if (o_parity_err) pe_cnt++;
            m_pe = 1'b0;
`endif
            if (o_frame_err) fe_cnt++;
            if (o_overrun) ovr_cnt++;
            if (o_valid && !prev_valid) rise_cyc = cyc;

            // expectation for the next cycle
            m_fe  = 1'b0;
            m_ovr = 1'b0;
            if (ev_q.size() > 0 && ev_q[0].lc == cyc + 1) begin
                if (ev_q[0].ok) begin
                    m_ovr   = m_valid && !i_read;
                    m_valid = 1'b1;
                    m_data  = ev_q[0].d;
`ifdef RX_UNIT_PARITY_EN
                    m_pe    = ev_q[0].pe;
`endif
                end else begin
                    m_fe = 1'b1;
                end
                void'(ev_q.pop_front());
            end else begin
                m_valid = m_valid && !i_read;
            end
        end
        prev_valid = o_valid;
    end

    // one bit period, starting just after a rising edge
    task automatic drive_bit(input logic v);
        @(posedge i_clock);
        #1;
        i_rx = v;
        repeat (CPB - 1) @(posedge i_clock);
    endtask

    task automatic send(input logic [DW-1:0] d, input bit par, input bit stop, output int k);
        int lc;
        @(posedge i_clock);
        #1;
        k  = cyc;
        // 2 sync flops + 1 detect, half a bit to the start mid-point, then
        // one bit period per remaining bit up to the stop mid-point
        lc = k + 3 + CPB / 2 + (DW + PB + 1) * CPB;
        ev_q.push_back('{lc: lc, d: d, ok: stop, pe: (par != ^d)});
        busy_lo.push_back(k + 3);
        busy_hi.push_back(lc);
        i_rx = 1'b0;
        repeat (CPB - 1) @(posedge i_clock);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
`ifdef RX_UNIT_PARITY_EN
        drive_bit(par);
`endif
        drive_bit(stop);
        if (!stop) begin
            // hold the break one more bit before releasing the line
            repeat (CPB) @(posedge i_clock);
            #1;
            i_rx = 1'b1;
        end
    endtask

    task automatic do_read();
        @(posedge i_clock);
        #1;
        i_read = 1'b1;
        @(posedge i_clock);
        #1;
        i_read = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        i_reset = 1'b1;
        i_rx    = 1'b1;
        i_read  = 1'b0;
        repeat (3) @(posedge i_clock);
        @(negedge i_clock);
        #1;
        chk("init_valid", 32'(o_valid), 0);
        chk("init_data", 32'(o_rxdata), 0);
        @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        repeat (5) @(posedge i_clock);

        // good frame 0xA5, then read
        fe_cnt = 0;
        ovr_cnt = 0;
        send(8'hA5, ^8'hA5, 1'b1, k);
        @(negedge i_clock);
        #1;
        chk("a5_data", 32'(o_rxdata), 32'h0000_00A5);
        chk("a5_valid", 32'(o_valid), 1);
        chk("a5_latency", 32'(rise_cyc - k), 32'(LAT_LIT));
        do_read();
        @(negedge i_clock);
        #1;
        chk("a5_read_clears", 32'(o_valid), 0);

        // 4-cycle glitch on idle line
        repeat (CPB) @(posedge i_clock);
        #1;
        k = cyc;
        busy_lo.push_back(k + 3);
        busy_hi.push_back(k + 3 + CPB / 2);
        i_rx = 1'b0;
        repeat (4) @(posedge i_clock);
        #1;
        i_rx = 1'b1;
        repeat (3 * CPB) @(posedge i_clock);
        @(negedge i_clock);
        #1;
        chk("glitch_valid", 32'(o_valid), 0);
        chk("glitch_ferr_cnt", 32'(fe_cnt), 0);
        chk("glitch_busy", 32'(o_busy), 0);

        // 0x3C with low stop bit followed by a break
        send(8'h3C, ^8'h3C, 1'b0, k);
        repeat (3 * CPB) @(posedge i_clock);
        @(negedge i_clock);
        #1;
        chk("ferr_cnt", 32'(fe_cnt), 1);
        chk("ferr_valid", 32'(o_valid), 0);
        chk("ferr_data_kept", 32'(o_rxdata), 32'h0000_00A5);

        // back-to-back 0x11, 0x22 without reading
        ovr_cnt = 0;
        send(8'h11, ^8'h11, 1'b1, k);
        send(8'h22, ^8'h22, 1'b1, k);
        @(negedge i_clock);
        #1;
        chk("ovr_cnt", 32'(ovr_cnt), 1);
        chk("ovr_data", 32'(o_rxdata), 32'h0000_0022);
        chk("ovr_valid", 32'(o_valid), 1);
        do_read();
        repeat (CPB) @(posedge i_clock);

        // reset during bit 3 of 0xFF, then 0x5A
        @(posedge i_clock);
        #1;
        k = cyc;
        busy_lo.push_back(k + 3);
        busy_hi.push_back(k + 100000);
        i_rx = 1'b0;
        repeat (CPB - 1) @(posedge i_clock);
        for (int i = 0; i < 3; i++) drive_bit(1'b1);
        @(posedge i_clock);
        #1;
        i_rx = 1'b1;
        repeat (CPB / 2) @(posedge i_clock);
        #1;
        chk("pre_rst_busy", 32'(o_busy), 1);
        i_reset = 1'b1;
        repeat (3) @(posedge i_clock);
        @(negedge i_clock);
        #1;
        chk("mid_rst_data", 32'(o_rxdata), 0);
        chk("mid_rst_busy", 32'(o_busy), 0);
        @(posedge i_clock);
        #1;
        i_reset = 1'b0;
        repeat (2 * CPB) @(posedge i_clock);
        send(8'h5A, ^8'h5A, 1'b1, k);
        @(negedge i_clock);
        #1;
        chk("post_rst_data", 32'(o_rxdata), 32'h0000_005A);
        chk("post_rst_valid", 32'(o_valid), 1);
        do_read();

`ifdef RX_UNIT_PARITY_EN
        // 0x07 has odd weight, so a parity bit of 0 is a mismatch
        pe_cnt = 0;
        repeat (CPB) @(posedge i_clock);
        send(8'h07, 1'b0, 1'b1, k);
        @(negedge i_clock);
        #1;
        chk("par_cnt", 32'(pe_cnt), 1);
        chk("par_data", 32'(o_rxdata), 32'h0000_0007);
        chk("par_valid", 32'(o_valid), 1);
        do_read();
`endif

        repeat (2 * CPB) @(posedge i_clock);
        @(negedge i_clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
